instr_encoder: RTL and testbench

- Write-side counterpart of the pipeline's instruction decoder.
- Accepts symbolic micro-op requests (operation plus register and immediate fields) over a valid/ready handshake and encodes each into a 32-bit MIPS word for the supported subset: nop, add, sub, ori, lw, sw, beq, lui, jal, jr.
- Writes the words sequentially into the instruction-memory write port, starting at the PC base address.
- Used as a program loader and for self-checking decoder benches.

---
 rtl/instr_encoder_if.sv | 15 +
 rtl/instr_encoder.sv | 151 +++++++++++++++
 tb/tb_instr_encoder.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// Request channel into the instruction encoder: one symbolic micro-op per
// valid/ready handshake.
interface instr_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  op;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [15:0] imm;
   logic [25:0] target;

   modport master (output in_valid, op, rs, rt, rd, imm, target, input in_ready);
   modport slave  (input in_valid, op, rs, rt, rd, imm, target, output in_ready);
endinterface

// File: rtl/instr_encoder.sv
// Encodes symbolic micro-ops into MIPS words and streams them into the
// instruction-memory write port starting at BASE_ADDR.
module instr_encoder #(
   parameter int          ADDR_W    = 12,
   parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              clear,
   instr_encoder_if.slave    req,
   output logic              im_we,
   output logic [31:0]       im_addr,
   output logic [31:0]       im_wdata,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FULL = 2'd2,
      S_ERR  = 2'd3
   } state_t;

   localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

   state_t            state_r;
   logic              in_ready_r;
   logic              im_we_r;
   logic [31:0]       im_addr_r;
   logic [31:0]       im_wdata_r;
   logic [ADDR_W:0]   count_r;
   logic              full_r;
   logic              err_r;

   logic              accept_s;
   logic              legal_s;
   logic [ADDR_W:0]   count_next_s;
   logic [ADDR_W:0]   accepted_s;
   logic [31:0]       word_s;

   function automatic logic op_legal(input logic [3:0] op);
      return (op <= 4'd9);
   endfunction

   function automatic logic [31:0] encode(input logic [3:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [15:0] imm, input logic [25:0] target);
      logic [31:0] w;
      case (op)
         4'd0:    w = 32'h0000_0000;
         4'd1:    w = {6'h00, rs, rt, rd, 5'b00000, 6'h20};
         4'd2:    w = {6'h00, rs, rt, rd, 5'b00000, 6'h22};
         4'd3:    w = {6'h0D, rs, rt, imm};
         4'd4:    w = {6'h23, rs, rt, imm};
         4'd5:    w = {6'h2B, rs, rt, imm};
         4'd6:    w = {6'h04, rs, rt, imm};
         4'd7:    w = {6'h0F, 5'b00000, rt, imm};
         4'd8:    w = {6'h03, target};
         4'd9:    w = {6'h00, rs, 15'b0, 6'h08};
         default: w = 32'h0000_0000;
      endcase
      return w;
   endfunction

   assign req.in_ready = in_ready_r;
   assign im_we        = im_we_r;
   assign im_addr      = im_addr_r;
   assign im_wdata     = im_wdata_r;
   assign count        = count_r;
   assign full         = full_r;
   assign err          = err_r;

   // Handshake decode and occupancy: accepted_s counts words committed after this edge.
   always_comb begin
      accept_s     = req.in_valid && in_ready_r && !clear;
      legal_s      = op_legal(req.op);
      word_s       = encode(req.op, req.rs, req.rt, req.rd, req.imm, req.target);
      count_next_s = count_r + {{ADDR_W{1'b0}}, im_we_r};
      if (accept_s && legal_s) begin
         accepted_s = count_next_s + {{ADDR_W{1'b0}}, 1'b1};
      end else begin
         accepted_s = count_next_s;
      end
   end

   // Control FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= S_IDLE;
         in_ready_r <= 1'b0;
         im_we_r    <= 1'b0;
         im_addr_r  <= BASE_ADDR;
         im_wdata_r <= 32'h0000_0000;
         count_r    <= '0;
         full_r     <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         count_r <= count_next_s;
         im_we_r <= accept_s && legal_s;
         if (accept_s && legal_s) begin
            im_wdata_r <= word_s;
            im_addr_r  <= BASE_ADDR + (32'(count_next_s) << 2);
         end else begin
            im_wdata_r <= im_wdata_r;
            im_addr_r  <= im_addr_r;
         end
         if (clear) begin
            state_r    <= S_IDLE;
            in_ready_r <= 1'b0;
            err_r      <= 1'b0;
         end else begin
            case (state_r)
               S_IDLE: begin
                  if (start) begin
                     state_r    <= S_RUN;
                     count_r    <= '0;
                     full_r     <= 1'b0;
                     in_ready_r <= 1'b1;
                  end else begin
                     in_ready_r <= 1'b0;
                  end
               end
               S_RUN: begin
                  if (accept_s && !legal_s) begin
                     state_r    <= S_ERR;
                     err_r      <= 1'b1;
                     in_ready_r <= 1'b0;
                  end else if (count_next_s == CAP) begin
                     state_r    <= S_FULL;
                     full_r     <= 1'b1;
                     in_ready_r <= 1'b0;
                  end else begin
                     // Drop ready as soon as the last slot has been claimed.
                     in_ready_r <= (accepted_s < CAP);
                  end
               end
               S_FULL:  in_ready_r <= 1'b0;
               S_ERR:   in_ready_r <= 1'b0;
               default: begin
                  state_r    <= S_IDLE;
                  in_ready_r <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed test-plan steps plus randomized traffic
// checked against a transaction-level model of the loader.
module tb_instr_encoder;
   localparam logic [31:0] BASE = 32'h0000_3000;
   localparam int CAP = 4096;

   logic clk = 1'b0;
   logic reset, start, clear, start2, clear2;
   logic im_we, full, err, im_we2, full2, err2;
   logic [31:0] im_addr, im_wdata, im_addr2, im_wdata2;
   logic [12:0] count;
   logic [2:0]  count2;

   instr_encoder_if rq ();
   instr_encoder_if rq2 ();

   instr_encoder #(.ADDR_W(12), .BASE_ADDR(BASE)) dut (
      .clk(clk), .reset(reset), .start(start), .clear(clear), .req(rq),
      .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
      .count(count), .full(full), .err(err));

   instr_encoder #(.ADDR_W(2), .BASE_ADDR(BASE)) dut_s (
      .clk(clk), .reset(reset), .start(start2), .clear(clear2), .req(rq2),
      .im_we(im_we2), .im_addr(im_addr2), .im_wdata(im_wdata2),
      .count(count2), .full(full2), .err(err2));

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Loader model: phase 0 idle, 1 running, 2 full, 3 error.
   int          m_phase = 0;
   int          m_count = 0;
   int          m_total = 0;
   bit          m_we = 1'b0;
   bit          m_ready = 1'b0;
   bit          m_full = 1'b0;
   bit          m_err = 1'b0;
   logic [31:0] m_addr = BASE;
   logic [31:0] m_data = 32'h0;

   function automatic logic [31:0] ref_word(input int op, input int rs, input int rt,
                                            input int rd, input int imm, input int tgt);
      case (op)
         1: return 32'((rs << 21) | (rt << 16) | (rd << 11) | 32);
         2: return 32'((rs << 21) | (rt << 16) | (rd << 11) | 34);
         3: return 32'((13 << 26) | (rs << 21) | (rt << 16) | imm);
         4: return 32'((35 << 26) | (rs << 21) | (rt << 16) | imm);
         5: return 32'((43 << 26) | (rs << 21) | (rt << 16) | imm);
         6: return 32'((4 << 26) | (rs << 21) | (rt << 16) | imm);
         7: return 32'((15 << 26) | (rt << 16) | imm);
         8: return 32'((3 << 26) | tgt);
         9: return 32'((rs << 21) | 8);
         default: return 32'h0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int op, input int rs, input int rt, input int rd,
                          input int imm, input int tgt);
      rq.in_valid = 1'b1;
      rq.op = 4'(op); rq.rs = 5'(rs); rq.rt = 5'(rt); rq.rd = 5'(rd);
      rq.imm = 16'(imm); rq.target = 26'(tgt);
   endtask

   // One clock: advance the model with the applied inputs, then compare.
   task automatic step();
      bit acc, leg, nwe;
      acc = rq.in_valid && m_ready && !clear;
      @(posedge clk);
      if (reset) begin
         m_phase = 0; m_count = 0; m_total = 0; m_we = 1'b0; m_ready = 1'b0;
         m_full = 1'b0; m_err = 1'b0; m_addr = BASE; m_data = 32'h0;
      end else begin
         if (m_we) m_count++;
         leg = (int'(rq.op) <= 9);
         nwe = acc && leg;
         if (nwe) begin
            m_addr = BASE + 32'(4 * m_total);
            m_data = ref_word(int'(rq.op), int'(rq.rs), int'(rq.rt), int'(rq.rd),
                              int'(rq.imm), int'(rq.target));
            m_total++;
         end
         if (clear) begin
            m_phase = 0; m_err = 1'b0; m_ready = 1'b0;
         end else if (m_phase == 0) begin
            if (start) begin
               m_phase = 1; m_count = 0; m_total = 0; m_full = 1'b0; m_ready = 1'b1;
            end
         end else if (m_phase == 1) begin
            if (acc && !leg) begin
               m_phase = 3; m_err = 1'b1; m_ready = 1'b0;
            end else if (m_count == CAP) begin
               m_phase = 2; m_full = 1'b1; m_ready = 1'b0;
            end else begin
               m_ready = (m_total < CAP);
            end
         end else begin
            m_ready = 1'b0;
         end
         m_we = nwe;
      end
      #1;
      chk("im_we", {31'b0, im_we}, {31'b0, m_we});
      if (m_we) begin
         chk("im_addr", im_addr, m_addr);
         chk("im_wdata", im_wdata, m_data);
      end
      chk("count", {19'b0, count}, 32'(m_count));
      chk("full", {31'b0, full}, {31'b0, m_full});
      chk("err", {31'b0, err}, {31'b0, m_err});
      chk("in_ready", {31'b0, rq.in_ready}, {31'b0, m_ready});
   endtask

   task automatic pulse_clear();
      clear = 1'b1; step(); clear = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1; step(); start = 1'b0;
   endtask

   initial begin
      int nwr;
      reset = 1'b1; start = 1'b0; clear = 1'b0; start2 = 1'b0; clear2 = 1'b0;
      rq.in_valid = 1'b0; rq.op = 4'd0; rq.rs = 5'd0; rq.rt = 5'd0; rq.rd = 5'd0;
      rq.imm = 16'd0; rq.target = 26'd0;
      rq2.in_valid = 1'b0; rq2.op = 4'd1; rq2.rs = 5'd1; rq2.rt = 5'd2; rq2.rd = 5'd3;
      rq2.imm = 16'd0; rq2.target = 26'd0;

      step(); step();
      reset = 1'b0;
      chk("rst_we", {31'b0, im_we}, 32'd0);
      chk("rst_addr", im_addr, 32'h0000_3000);
      chk("rst_wdata", im_wdata, 32'd0);
      chk("rst_count", {19'b0, count}, 32'd0);
      chk("rst_ready", {31'b0, rq.in_ready}, 32'd0);
      step();

      // First word
      pulse_start();
      chk("ready_after_start", {31'b0, rq.in_ready}, 32'd1);
      set_req(1, 1, 2, 3, 0, 0); step(); rq.in_valid = 1'b0;
      chk("add_we", {31'b0, im_we}, 32'd1);
      chk("add_addr", im_addr, 32'h0000_3000);
      chk("add_word", im_wdata, 32'h0022_1820);
      step();
      chk("add_count", {19'b0, count}, 32'd1);

      // Back-to-back stream with masked fields
      pulse_clear(); pulse_start();
      set_req(3, 0, 5, 0, 16'h1234, 0); step();
      chk("ori_word", im_wdata, 32'h3405_1234); chk("ori_addr", im_addr, 32'h0000_3000);
      set_req(7, 7, 4, 0, 16'hFFFF, 0); step();
      chk("lui_word", im_wdata, 32'h3C04_FFFF); chk("lui_addr", im_addr, 32'h0000_3004);
      set_req(5, 1, 2, 0, 8, 0); step();
      chk("sw_word", im_wdata, 32'hAC22_0008); chk("sw_addr", im_addr, 32'h0000_3008);
      set_req(6, 1, 2, 0, 16'hFFFF, 0); step();
      chk("beq_word", im_wdata, 32'h1022_FFFF); chk("beq_we", {31'b0, im_we}, 32'd1);
      set_req(8, 3, 4, 5, 16'hABCD, 26'h0000C00); step();
      chk("jal_word", im_wdata, 32'h0C00_0C00);
      set_req(9, 31, 0, 9, 0, 0); step();
      chk("jr_word", im_wdata, 32'h03E0_0008); chk("jr_addr", im_addr, 32'h0000_3014);
      rq.in_valid = 1'b0; step();
      chk("stream_count", {19'b0, count}, 32'd6);

      // Illegal op, then recovery
      pulse_clear(); pulse_start();
      set_req(2, 4, 5, 6, 0, 0); step(); rq.in_valid = 1'b0; step();
      set_req(15, 1, 1, 1, 0, 0); step(); rq.in_valid = 1'b0;
      chk("ill_we", {31'b0, im_we}, 32'd0);
      chk("ill_err", {31'b0, err}, 32'd1);
      chk("ill_ready", {31'b0, rq.in_ready}, 32'd0);
      chk("ill_count", {19'b0, count}, 32'd1);
      pulse_clear();
      chk("clr_err", {31'b0, err}, 32'd0);
      pulse_start();
      set_req(1, 1, 2, 3, 0, 0); step(); rq.in_valid = 1'b0;
      chk("restart_addr", im_addr, 32'h0000_3000);
      step();

      // Randomized traffic, including stray starts, clears and illegal ops
      for (int i = 0; i < 400; i++) begin
         start = ($urandom_range(0, 7) == 0);
         clear = ($urandom_range(0, 39) == 0);
         rq.in_valid = ($urandom_range(0, 9) < 7);
         rq.op = ($urandom_range(0, 49) == 0) ? 4'($urandom_range(10, 15))
                                              : 4'($urandom_range(0, 9));
         rq.rs = 5'($urandom); rq.rt = 5'($urandom); rq.rd = 5'($urandom);
         rq.imm = 16'($urandom); rq.target = 26'($urandom);
         step();
      end
      start = 1'b0; clear = 1'b0; rq.in_valid = 1'b0;

      // Reset in the write cycle after an accept
      pulse_clear(); pulse_start();
      set_req(4, 2, 3, 0, 16'h0010, 0); step(); rq.in_valid = 1'b0;
      reset = 1'b1; step(); reset = 1'b0;
      chk("mid_rst_we", {31'b0, im_we}, 32'd0);
      chk("mid_rst_count", {19'b0, count}, 32'd0);
      chk("mid_rst_addr", im_addr, 32'h0000_3000);
      chk("mid_rst_ready", {31'b0, rq.in_ready}, 32'd0);
      step();

      // Capacity limit on the 4-word instance
      start2 = 1'b1; step(); start2 = 1'b0;
      rq2.in_valid = 1'b1;
      nwr = 0;
      for (int i = 0; i < 7; i++) begin
         step();
         if (im_we2 === 1'b1) begin
            chk("small_addr", im_addr2, BASE + 32'(4 * nwr));
            chk("small_word", im_wdata2, 32'h0022_1820);
            nwr++;
         end
      end
      rq2.in_valid = 1'b0;
      chk("small_writes", 32'(nwr), 32'd4);
      chk("small_full", {31'b0, full2}, 32'd1);
      chk("small_ready", {31'b0, rq2.in_ready}, 32'd0);
      chk("small_count", {29'b0, count2}, 32'd4);
      chk("small_err", {31'b0, err2}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
